snn_neuron_scheduler: RTL and testbench
=======================================

# snn_neuron_scheduler

Time-multiplexed controller that shares one leaky-integrate-fire update datapath across `N_NEURONS` virtual neurons. On each time-step request it walks every neuron in index order, one neuron per cycle. For each neuron it reads the input current, applies the LIF update to that neuron's stored membrane/refractory state and pushes spike events into an output FIFO. It sits between the design's input-current source and the spike consumer (output pins or next layer).

## Interface
Parameters:
- `N_NEURONS`, 4, number of virtual neurons (2..16)
- `FIFO_DEPTH`, 4, spike event FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `step_start`  in  1  one-cycle request to run one time step
- `threshold`  in  8  spiking threshold, sampled at step start
- `leak_rate`  in  8  per-step leak, sampled at step start
- `refrac_period`  in  8  refractory length in steps, sampled at step start
- `cur_idx`  out  clog2(N_NEURONS)  neuron whose current is requested
- `cur_data`  in  8  current for `cur_idx`, combinational, same cycle
- `busy`  out  1  step in progress
- `step_done`  out  1  one-cycle pulse when a step completes
- `spk_valid`  out  1  FIFO head valid
- `spk_ready`  in  1  consumer accepts head
- `spk_id`  out  clog2(N_NEURONS)  neuron index of head spike
- `spk_overflow`  out  1  sticky; a spike was dropped

## Operation
- FSM states: IDLE, UPDATE, DONE.
- IDLE:
  - `step_start`=1 → UPDATE, idx=0.
  - Capture `threshold`, `leak_rate` and `refrac_period` into shadow registers.
- UPDATE, neuron idx with state v (8b), rc (8b), rf (1b):
  - If rf=1: rc←rc−1. If rc−1==0 then rf←0. v is unchanged, no spike.
  - Else compute s = min(v+cur_data, 255) on 9-bit add, then u = (s ≥ leak) ? s−leak : 0.
  - If u ≥ threshold: spike, v←0, rc←refrac_period, rf←(refrac_period≠0).
  - Otherwise v←u.
  - A neuron with refrac_period=P skips exactly P subsequent steps.
- Spike push:
  - If the FIFO is not full, push idx.
  - If full: hold idx and do not commit state (stall) until space frees. Stall lasts at most until a pop.
  - `spk_overflow` is set only when the FIFO is full at DONE-entry drop; it is not used in normal flow. It is reserved and is cleared only by reset.
- idx==N_NEURONS−1 committed → DONE. DONE → IDLE after one cycle with `step_done`=1.
- `step_start` while busy is ignored; it is not queued.
- FIFO pop when `spk_valid && spk_ready`. Simultaneous push and pop on a full FIFO is allowed and does not stall.
- `cur_idx` = idx in UPDATE, 0 otherwise.

## Timing
- Reset values: all neuron v/rc/rf=0, FSM=IDLE, FIFO empty, `busy`=0, `step_done`=0, `spk_valid`=0, `spk_id`=0, `spk_overflow`=0, `cur_idx`=0.
- `busy`=1 from the cycle after `step_start` through the DONE cycle.
- Unstalled step: N_NEURONS UPDATE cycles + 1 DONE cycle. `step_done` is asserted N_NEURONS+1 cycles after `step_start`.
- Push is visible as `spk_valid` the cycle after the neuron's UPDATE cycle.
- FIFO head is registered. `spk_id` is stable while `spk_valid && !spk_ready`.
- Reset mid-step: immediate return to reset state. Partial step is discarded and FIFO contents are lost.

## Structure
- Package `snn_pkg`:
  - `NEURON_W=8`
  - `neuron_state_t` struct {v, rc, rf}
  - FSM state enum
  - saturating-add helper function
- Sub-module `lif_update_unit`: purely combinational. Inputs {state, current, threshold, leak, refrac}; outputs {next_state, spike}. It is instantiated once.
- The FIFO is a plain `spike_fifo` sub-module parameterized on depth and width.

## Test plan
- Reset, N=4, threshold=10, leak=1, refrac=2, all currents 5.
  - Step 1: no spikes (v=4).
  - Step 2: no spikes (v=8).
  - Step 3: spikes ids 0,1,2,3 in order.
  - Steps 4–5: no spikes, v stays 0.
  - Step 6: v=4.
- Current 200 into v=100 with leak=0, threshold=255: s saturates to 255 → spike.
- Current 0, leak=5, v=3: v→0, no underflow wrap.
- refrac=0, threshold=0: every neuron spikes every step, rf never set.
- `spk_ready`=0, FIFO_DEPTH=4, all 4 neurons spike. Check:
  - No stall.
  - `step_done` at cycle 5.
  - Next step stalls at idx 0 until one pop.
  - `busy` stays high during the stall.
- Assert `rst_n`=0 at idx=2. All outputs return to reset values that cycle. The next step starts from v=0 for all neurons.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
//   NEURON_W       : width of membrane potential, refractory counter and LIF parameters
//   neuron_state_t : per-neuron stored state {v, rc, rf}
//   sched_state_e  : scheduler FSM states
//   sat_add()      : unsigned add clamped to the all-ones value
package snn_pkg;

    localparam int NEURON_W = 8;

    typedef struct packed {
        logic [NEURON_W-1:0] v;   // membrane potential
        logic [NEURON_W-1:0] rc;  // remaining refractory steps
        logic                rf;  // neuron is refractory
    } neuron_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } sched_state_e;

    // One extra bit catches the carry; any carry clamps to the maximum value.
    function automatic logic [NEURON_W-1:0] sat_add(input logic [NEURON_W-1:0] a,
                                                     input logic [NEURON_W-1:0] b);
        logic [NEURON_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[NEURON_W] ? '1 : sum[NEURON_W-1:0];
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky-integrate-fire update for one neuron.
//   state_i      : stored state of the neuron being updated
//   current_i    : input current for this neuron
//   threshold_i  : spiking threshold
//   leak_i       : per-step leak subtracted after integration
//   refrac_i     : refractory length (steps) loaded on a spike
//   next_state_o : state to commit
//   spike_o      : neuron fires this step
module lif_update_unit
    import snn_pkg::*;
(
    input  neuron_state_t       state_i,
    input  logic [NEURON_W-1:0] current_i,
    input  logic [NEURON_W-1:0] threshold_i,
    input  logic [NEURON_W-1:0] leak_i,
    input  logic [NEURON_W-1:0] refrac_i,
    output neuron_state_t       next_state_o,
    output logic                spike_o
);

    logic [NEURON_W-1:0] sum_sat;
    logic [NEURON_W-1:0] leaked;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        next_state_o = state_i;
        spike_o      = 1'b0;
        sum_sat      = sat_add(state_i.v, current_i);
        // Leak floors at zero instead of wrapping.
        leaked       = (sum_sat >= leak_i) ? sum_sat - leak_i : '0;

        if (state_i.rf) begin
            // Refractory: count down, leave v alone, never fire.
            next_state_o.rc = state_i.rc - NEURON_W'(1);
            next_state_o.rf = (state_i.rc != NEURON_W'(1));
        end else if (leaked >= threshold_i) begin
            spike_o         = 1'b1;
            next_state_o.v  = '0;
            next_state_o.rc = refrac_i;
            // A zero refractory period means the neuron stays live next step.
            next_state_o.rf = (refrac_i != '0);
        end else begin
            next_state_o.v  = leaked;
        end
    end

endmodule

// File: rtl/spike_fifo.sv
// Synchronous FIFO holding spike neuron indices.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write request; accepted when push_ready_o is high
//   push_data_i  : value to write
//   push_ready_o : space available (a same-cycle pop frees a full FIFO)
//   pop_i        : consumer accepts the head; ignored when empty
//   valid_o      : head entry present
//   data_o       : head entry, zero when empty
module spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full         = (count_q == (AW+1)'(DEPTH));
    assign valid_o      = (count_q != '0);
    assign do_pop       = pop_i & valid_o;
    assign push_ready_o = ~full | do_pop;
    assign do_push      = push_i & push_ready_o;
    assign data_o       = valid_o ? mem_q[rd_ptr_q] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage is not reset; the occupancy count gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: one update datapath walks N_NEURONS virtual
// neurons, one per cycle, on every time-step request and queues spike events.
//   clk, rst_n     : clock, asynchronous active-low reset
//   step_start     : one-cycle request to run a time step (ignored while busy)
//   threshold, leak_rate, refrac_period : LIF parameters, sampled at step start
//   cur_idx        : neuron whose current is requested (0 outside UPDATE)
//   cur_data       : current for cur_idx, same cycle
//   busy           : step in progress
//   step_done      : one-cycle pulse as the step completes
//   spk_valid, spk_ready, spk_id : spike FIFO head handshake
//   spk_overflow   : sticky dropped-spike flag, cleared only by reset
module snn_neuron_scheduler
    import snn_pkg::*;
#(
    parameter  int N_NEURONS  = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_start,
    input  logic [NEURON_W-1:0] threshold,
    input  logic [NEURON_W-1:0] leak_rate,
    input  logic [NEURON_W-1:0] refrac_period,
    output logic [IDX_W-1:0]    cur_idx,
    input  logic [NEURON_W-1:0] cur_data,
    output logic                busy,
    output logic                step_done,
    output logic                spk_valid,
    input  logic                spk_ready,
    output logic [IDX_W-1:0]    spk_id,
    output logic                spk_overflow
);

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NEURON_W-1:0] thr_q, leak_q, refrac_q;
    neuron_state_t       neurons_q [N_NEURONS];
    neuron_state_t       lif_next;
    logic                lif_spike;
    logic                in_update;
    logic                push_req;
    logic                fifo_push_ready;
    logic                stall;
    logic                commit;
    logic                last_idx;
    logic                spk_drop;
    logic                overflow_q;

    lif_update_unit u_lif (
        .state_i      (neurons_q[idx_q]),
        .current_i    (cur_data),
        .threshold_i  (thr_q),
        .leak_i       (leak_q),
        .refrac_i     (refrac_q),
        .next_state_o (lif_next),
        .spike_o      (lif_spike)
    );

    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_req),
        .push_data_i  (idx_q),
        .push_ready_o (fifo_push_ready),
        .pop_i        (spk_ready),
        .valid_o      (spk_valid),
        .data_o       (spk_id)
    );

    assign in_update = (state_q == ST_UPDATE);
    assign push_req  = in_update & lif_spike;
    // A spike with no FIFO space holds the neuron uncommitted until a pop frees a slot.
    assign stall     = push_req & ~fifo_push_ready;
    assign commit    = in_update & ~stall;
    assign last_idx  = (idx_q == IDX_W'(N_NEURONS - 1));
    // Dropping would mean committing a neuron whose push was refused; the stall
    // prevents that, so the sticky flag records only a broken invariant.
    assign spk_drop  = push_req & ~fifo_push_ready & commit;

    assign busy         = (state_q != ST_IDLE);
    assign step_done    = (state_q == ST_DONE);
    assign cur_idx      = in_update ? idx_q : '0;
    assign spk_overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (step_start) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (commit) begin
                    if (last_idx) state_d = ST_DONE;
                    else          idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            thr_q      <= '0;
            leak_q     <= '0;
            refrac_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Parameters are frozen for the whole step.
            if (state_q == ST_IDLE && step_start) begin
                thr_q    <= threshold;
                leak_q   <= leak_rate;
                refrac_q <= refrac_period;
            end
            if (spk_drop) overflow_q <= 1'b1;
        end
    end

    // Neuron state is architectural: every neuron must restart from zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) neurons_q[i] <= '0;
        end else if (commit) begin
            neurons_q[idx_q] <= lif_next;
        end
    end

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
module tb_snn_neuron_scheduler;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             step_start;
    logic [7:0]       threshold;
    logic [7:0]       leak_rate;
    logic [7:0]       refrac_period;
    logic [IDX_W-1:0] cur_idx;
    logic [7:0]       cur_data;
    logic             busy;
    logic             step_done;
    logic             spk_valid;
    logic             spk_ready;
    logic [IDX_W-1:0] spk_id;
    logic             spk_overflow;

    logic [7:0] cur_tbl [N];
    assign cur_data = cur_tbl[cur_idx];

    snn_neuron_scheduler #(.N_NEURONS(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_start    (step_start),
        .threshold     (threshold),
        .leak_rate     (leak_rate),
        .refrac_period (refrac_period),
        .cur_idx       (cur_idx),
        .cur_data      (cur_data),
        .busy          (busy),
        .step_done     (step_done),
        .spk_valid     (spk_valid),
        .spk_ready     (spk_ready),
        .spk_id        (spk_id),
        .spk_overflow  (spk_overflow)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int popped = 0;
    int step_popped = 0;
    int ready_mode = 0;  // 0: never ready, 1: always ready, 2: random

    // Behavioural model: per-neuron integers plus the expected spike order.
    int mv [N];
    int mrc [N];
    int mrf [N];
    int exp_q [$];

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; mrc[i] = 0; mrf[i] = 0;
        end
        exp_q.delete();
    endtask

    // One whole time step evaluated from the update rules on plain integers.
    task automatic model_step(input int thr, input int leak, input int refr, output int n);
        int s;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (mrf[i] != 0) begin
                mrc[i] = mrc[i] - 1;
                if (mrc[i] == 0) mrf[i] = 0;
            end else begin
                s = mv[i] + int'(cur_tbl[i]);
                if (s > 255) s = 255;
                s = (s >= leak) ? s - leak : 0;
                if (s >= thr) begin
                    exp_q.push_back(i);
                    n++;
                    mv[i] = 0; mrc[i] = refr; mrf[i] = (refr != 0) ? 1 : 0;
                end else begin
                    mv[i] = s;
                end
            end
        end
    endtask

    task automatic set_all(input int c);
        for (int i = 0; i < N; i++) cur_tbl[i] = 8'(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_step_done"}, step_done, 0);
        check({tag, "_spk_valid"}, spk_valid, 0);
        check({tag, "_spk_id"},    spk_id, 0);
        check({tag, "_cur_idx"},   cur_idx, 0);
        check({tag, "_overflow"},  spk_overflow, 0);
    endtask

    task automatic do_reset(input int mode);
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_clear();
        ready_mode = mode;
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    // Runs one step from a point just after a falling edge. exp_lat < 0 skips the latency check.
    task automatic run_step(input int thr, input int leak, input int refr, input bit inject,
                            input int exp_lat, output int n_model);
        int lat;
        int pop0;
        threshold     = 8'(thr);
        leak_rate     = 8'(leak);
        refrac_period = 8'(refr);
        model_step(thr, leak, refr, n_model);
        pop0 = popped;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        lat = 1;
        check("busy_after_start", busy, 1);
        while (!step_done && lat < 300) begin
            @(negedge clk);
            lat++;
            step_start = (inject && lat == 2);
        end
        step_start = 1'b0;
        check("step_done_seen", step_done, 1);
        if (exp_lat > 0) check("step_latency", lat, exp_lat);
        @(negedge clk); #1;
        check("idle_after_done", busy, 0);
        check("done_is_pulse", step_done, 0);
        step_popped = popped - pop0;
    endtask

    // Consumer handshake, changed just after the rising edge.
    initial begin
        spk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       spk_ready = 1'b0;
                1:       spk_ready = 1'b1;
                default: spk_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: scoreboard on every accepted spike plus per-cycle output rules.
    initial begin
        bit               prev_hold;
        logic [IDX_W-1:0] prev_id;
        prev_hold = 1'b0;
        prev_id   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_hold) check("spk_id_stable", spk_id, prev_id);
                if (spk_valid && spk_ready) begin
                    check("spk_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("spk_id_order", spk_id, exp_q.pop_front());
                    popped++;
                end
                if (!busy) check("cur_idx_idle", cur_idx, 0);
                check("overflow_clear", spk_overflow, 0);
                prev_hold = spk_valid && !spk_ready;
                prev_id   = spk_id;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        int nm;
        int k;
        int pop0;
        int t1_exp [6];
        t1_exp = '{0, 0, 4, 0, 0, 0};

        rst_n = 1'b0; step_start = 1'b0;
        threshold = '0; leak_rate = '0; refrac_period = '0;
        set_all(0);
        model_clear();
        #3;
        check_reset_outputs("por");
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Integrate to threshold, then two refractory steps.
        do_reset(1);
        set_all(5);
        for (int s = 0; s < 6; s++) begin
            run_step(10, 1, 2, 1'b0, N + 1, nm);
            check($sformatf("t1_model_step%0d", s + 1), nm, t1_exp[s]);
            check($sformatf("t1_dut_step%0d", s + 1), step_popped, t1_exp[s]);
        end

        // Saturating add: v=100 plus 200 clamps to 255 and fires at threshold 255.
        do_reset(1);
        set_all(100);
        run_step(255, 0, 0, 1'b0, N + 1, nm);
        check("sat_prime_spikes", step_popped, 0);
        set_all(200);
        run_step(255, 0, 0, 1'b0, N + 1, nm);
        check("sat_model_spikes", nm, 4);
        check("sat_dut_spikes", step_popped, 4);

        // Leak larger than v floors at zero; a wrapped value would fire at 200.
        do_reset(1);
        set_all(3);
        run_step(255, 0, 0, 1'b0, N + 1, nm);
        set_all(0);
        run_step(255, 5, 0, 1'b0, N + 1, nm);
        check("leak_floor_step", step_popped, 0);
        run_step(200, 0, 0, 1'b0, N + 1, nm);
        check("leak_no_wrap_model", nm, 0);
        check("leak_no_wrap_dut", step_popped, 0);

        // Zero threshold and zero refractory period: every neuron fires every step.
        do_reset(1);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N; i++) cur_tbl[i] = 8'($urandom_range(0, 255));
            run_step(0, $urandom_range(0, 255), 0, 1'b0, N + 1, nm);
            check($sformatf("always_fire_dut%0d", s), step_popped, 4);
        end

        // Full FIFO without stalling, then a stall at idx 0 until the consumer pops.
        do_reset(0);
        set_all(0);
        pop0 = popped;
        run_step(0, 0, 0, 1'b0, N + 1, nm);
        check("fill_model_spikes", nm, 4);
        check("fill_spk_valid", spk_valid, 1);
        threshold = 8'd0; leak_rate = 8'd0; refrac_period = 8'd0;
        model_step(0, 0, 0, nm);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("stall_busy", busy, 1);
        check("stall_cur_idx", cur_idx, 0);
        check("stall_no_done", step_done, 0);
        check("stall_head_id", spk_id, 0);
        ready_mode = 1;
        k = 0;
        while (!step_done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("stall_released_done", step_done, 1);
        k = 0;
        while (exp_q.size() != 0 && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        check("stall_drain_empty", exp_q.size(), 0);
        check("stall_total_pops", popped - pop0, 8);

        // Reset in the middle of a step, at idx 2, after v has reached 8.
        do_reset(1);
        set_all(5);
        run_step(10, 1, 2, 1'b0, N + 1, nm);
        run_step(10, 1, 2, 1'b0, N + 1, nm);
        threshold = 8'd10; leak_rate = 8'd1; refrac_period = 8'd2;
        model_step(10, 1, 2, nm);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        k = 0;
        while (cur_idx != 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_idx2", cur_idx, 2);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            run_step(10, 1, 2, 1'b0, N + 1, nm);
            check($sformatf("post_rst_step%0d", s + 1), step_popped, (s == 2) ? 4 : 0);
        end

        // Randomized steps with a random consumer and ignored mid-step requests.
        do_reset(2);
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N; i++) cur_tbl[i] = 8'($urandom_range(0, 40));
            run_step($urandom_range(0, 80), $urandom_range(0, 10), $urandom_range(0, 3),
                     1'($urandom_range(0, 3) == 0), -1, nm);
        end
        ready_mode = 1;
        k = 0;
        while ((exp_q.size() != 0 || spk_valid) && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("final_drain_empty", exp_q.size(), 0);
        check("final_spk_valid", spk_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
